issue_scoreboard: RTL and testbench
===================================

Name: issue_scoreboard

Overview:
- Parametrised issue stage sitting between decode and the execute functional units (FUs).
- Holds a per-register pending-write scoreboard and detects RAW and WAW hazards, plus structural hazards on the target FU.
- Issues one instruction per cycle into a registered valid/ready output slot steered to NUM_FU units.
- Clears scoreboard entries on writeback and counts stall cycles.

Parameters:
- NUM_REGS, 32, architectural registers; register 0 is hard-wired and never pending.
- ADDR_W, 5, register address width (log2 NUM_REGS).
- NUM_FU, 3, number of functional units.
- FU_W, 2, width of the FU index.
- PAYLOAD_W, 96, width of the opaque decoded-control/operand bundle forwarded to execute.
- STALL_CNT_W, 16, width of the stall-cycle counter.

Ports:
- clock  in  1  system clock; all state is updated on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- id_iss_valid  in  1  decode presents an instruction.
- id_iss_srca  in  ADDR_W  source register A.
- id_iss_srcb  in  ADDR_W  source register B.
- id_iss_usesb  in  1  1 = B is a register operand (three-register form).
- id_iss_regdest  in  ADDR_W  destination register.
- id_iss_writereg  in  1  instruction writes regdest.
- id_iss_fu  in  FU_W  target FU index (< NUM_FU).
- id_iss_payload  in  PAYLOAD_W  forwarded unchanged.
- iss_flush  in  1  squash; no issue this cycle, output slot emptied.
- fu_ready  in  NUM_FU  per-FU accept.
- wb_valid  in  1  writeback completes.
- wb_addr  in  ADDR_W  writeback register.
- iss_ex_valid  out  1  output slot occupied.
- iss_ex_func_unit  out  FU_W  FU index of slot contents.
- iss_ex_regdest  out  ADDR_W  destination of slot contents.
- iss_ex_writereg  out  1  writereg of slot contents.
- iss_ex_payload  out  PAYLOAD_W  payload of slot contents.
- iss_stall  out  1  combinational; decode must hold its instruction.
- iss_pending_count  out  ADDR_W+1  number of pending registers.
- iss_stall_cycles  out  STALL_CNT_W  saturating count of stalled cycles.

Behaviour:
- Reset (async, active-high): all pending bits 0, iss_ex_valid 0, func_unit/regdest/writereg/payload 0, pending_count 0, stall_cycles 0. A reset asserted mid-operation discards the slot and the scoreboard immediately.
- Effective pending: pend_eff[r] = pending[r] & ~(wb_valid & wb_addr==r). Writeback is bypassed into the hazard check in the same cycle.
- RAW hazard: pend_eff[srca] | (usesb & pend_eff[srcb]). A source of 0 never hazards.
- WAW hazard: writereg & regdest!=0 & pend_eff[regdest].
- Slot accept: slot_free = ~iss_ex_valid | fu_ready[iss_ex_func_unit].
- Stall: iss_stall = id_iss_valid & (RAW | WAW | ~slot_free | iss_flush).
- Issue: issue = id_iss_valid & ~iss_stall.
  - Slot loads fu, regdest, writereg, payload; iss_ex_valid <= 1.
  - If writereg & regdest!=0, pending[regdest] <= 1.
- Slot drain: if no issue and the slot is free, iss_ex_valid <= 0; slot data is held otherwise.
- Slot stability: while iss_ex_valid & ~fu_ready[func_unit], all slot outputs are held stable.
- Flush: iss_ex_valid <= 0 and no issue that cycle. Pending bits set by earlier issues remain; the FU owning a squashed instruction must still signal wb_valid (with wb_addr) to release its pending bit.
- Writeback: wb_valid clears pending[wb_addr].
  - Same cycle, same register as an issue: set wins.
  - wb_addr 0: ignored.
  - Clearing a register that is not pending: no effect.
- Issue latency: 1 cycle from id_iss_valid (hazard-free) to iss_ex_valid. Back-to-back issue is permitted when fu_ready is held high.
- iss_pending_count: registered popcount of next pending state, range 0..NUM_REGS-1.
- iss_stall_cycles: increments on every cycle with iss_stall=1; saturates at all-ones and does not wrap.
- Out-of-range id_iss_fu (>= NUM_FU): treated as a structural stall; the instruction is never issued.

Test Plan:
- Reset, then issue add r3<-r1,r2 on FU0 with fu_ready=3'b111 -> next cycle iss_ex_valid=1, func_unit=0, regdest=3; pending_count=1.
- Next cycle issue r4<-r3,r1 -> RAW: iss_stall=1 and stall_cycles increments each cycle. Pulse wb_valid, wb_addr=3 -> same cycle iss_stall=0; issued next cycle; pending_count=1 (r4 only).
- With r5 pending, issue writereg r5 -> WAW stall. Writeback of r5 coincides with new issue to r5 -> pending[5] remains 1 and pending_count is unchanged.
- Slot holds FU2 with fu_ready[2]=0 for 4 cycles -> slot outputs stable, iss_stall=1 for a valid input. fu_ready[2]=1 -> slot accepts the new instruction in that cycle.
- Destination r0 with writereg=1 -> issues, pending_count stays 0. Source r0 never stalls. wb_addr=0 has no effect.
- Assert reset mid-stream with 3 registers pending and the slot full -> immediately iss_ex_valid=0, pending_count=0. Force 65535 stall cycles -> stall_cycles holds at 16'hFFFF.

Source files
------------

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: in-order issue stage with pending-write scoreboard, RAW/WAW/structural stall and registered output slot.
module issue_scoreboard #(
  parameter int NUM_REGS    = 32,
  parameter int ADDR_W      = 5,
  parameter int NUM_FU      = 3,
  parameter int FU_W        = 2,
  parameter int PAYLOAD_W   = 96,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   id_iss_valid,
  input  logic [ADDR_W-1:0]      id_iss_srca,
  input  logic [ADDR_W-1:0]      id_iss_srcb,
  input  logic                   id_iss_usesb,
  input  logic [ADDR_W-1:0]      id_iss_regdest,
  input  logic                   id_iss_writereg,
  input  logic [FU_W-1:0]        id_iss_fu,
  input  logic [PAYLOAD_W-1:0]   id_iss_payload,
  input  logic                   iss_flush,
  input  logic [NUM_FU-1:0]      fu_ready,
  input  logic                   wb_valid,
  input  logic [ADDR_W-1:0]      wb_addr,
  output logic                   iss_ex_valid,
  output logic [FU_W-1:0]        iss_ex_func_unit,
  output logic [ADDR_W-1:0]      iss_ex_regdest,
  output logic                   iss_ex_writereg,
  output logic [PAYLOAD_W-1:0]   iss_ex_payload,
  output logic                   iss_stall,
  output logic [ADDR_W:0]        iss_pending_count,
  output logic [STALL_CNT_W-1:0] iss_stall_cycles
);
  logic [NUM_REGS-1:0] pending, wb_mask, set_mask, pend_eff, pend_nxt;
  logic                raw, waw, slot_rdy, fu_ok, slot_free, issue;
  logic [ADDR_W:0]     cnt_nxt;
  // Writeback is bypassed so a same-cycle release unblocks the waiting instruction.
  assign wb_mask   = (wb_valid && wb_addr != '0) ? (NUM_REGS'(1) << wb_addr) : '0;
  assign pend_eff  = pending & ~wb_mask;
  assign raw       = pend_eff[id_iss_srca] | (id_iss_usesb & pend_eff[id_iss_srcb]);
  assign waw       = id_iss_writereg & (id_iss_regdest != '0) & pend_eff[id_iss_regdest];
  always_comb begin
    slot_rdy = 1'b0;
    fu_ok    = 1'b0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (iss_ex_func_unit == FU_W'(i)) slot_rdy = fu_ready[i];
      if (id_iss_fu == FU_W'(i)) fu_ok = 1'b1;
    end
  end
  assign slot_free = ~iss_ex_valid | slot_rdy;
  assign iss_stall = id_iss_valid & (raw | waw | ~slot_free | ~fu_ok | iss_flush);
  assign issue     = id_iss_valid & ~iss_stall;
  assign set_mask  = (issue && id_iss_writereg && id_iss_regdest != '0) ? (NUM_REGS'(1) << id_iss_regdest) : '0;
  assign pend_nxt  = pend_eff | set_mask;
  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++) cnt_nxt = cnt_nxt + (ADDR_W+1)'(pend_nxt[i]);
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending           <= '0;
      iss_pending_count <= '0;
      iss_stall_cycles  <= '0;
      iss_ex_valid      <= 1'b0;
      iss_ex_func_unit  <= '0;
      iss_ex_regdest    <= '0;
      iss_ex_writereg   <= 1'b0;
      iss_ex_payload    <= '0;
    end else begin
      pending           <= pend_nxt;
      iss_pending_count <= cnt_nxt;
      if (iss_stall && !(&iss_stall_cycles)) iss_stall_cycles <= iss_stall_cycles + 1'b1;
      if (issue) begin
        iss_ex_valid     <= 1'b1;
        iss_ex_func_unit <= id_iss_fu;
        iss_ex_regdest   <= id_iss_regdest;
        iss_ex_writereg  <= id_iss_writereg;
        iss_ex_payload   <= id_iss_payload;
      end else if (slot_free || iss_flush) begin
        iss_ex_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_issue_scoreboard.sv
// tb_issue_scoreboard: directed-vector bench for issue_scoreboard with immediate-assertion checks.
module tb_issue_scoreboard;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        id_iss_valid = 1'b0;
  logic [4:0]  id_iss_srca = '0, id_iss_srcb = '0, id_iss_regdest = '0, wb_addr = '0;
  logic        id_iss_usesb = 1'b0, id_iss_writereg = 1'b0, iss_flush = 1'b0, wb_valid = 1'b0;
  logic [1:0]  id_iss_fu = '0;
  logic [95:0] id_iss_payload = '0;
  logic [2:0]  fu_ready = 3'b111;
  logic        iss_ex_valid, iss_ex_writereg, iss_stall;
  logic [1:0]  iss_ex_func_unit;
  logic [4:0]  iss_ex_regdest;
  logic [95:0] iss_ex_payload;
  logic [5:0]  iss_pending_count;
  logic [15:0] iss_stall_cycles;
  int vectors = 0, miscompares = 0;
  localparam logic [95:0] P1 = 96'hA5A5_0000_1111_2222_3333_4444;
  localparam logic [95:0] P2 = 96'h5A5A_FFFF_EEEE_DDDD_CCCC_BBBB;

  issue_scoreboard dut (
    .clock(clock), .reset(reset), .id_iss_valid(id_iss_valid), .id_iss_srca(id_iss_srca),
    .id_iss_srcb(id_iss_srcb), .id_iss_usesb(id_iss_usesb), .id_iss_regdest(id_iss_regdest),
    .id_iss_writereg(id_iss_writereg), .id_iss_fu(id_iss_fu), .id_iss_payload(id_iss_payload),
    .iss_flush(iss_flush), .fu_ready(fu_ready), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .iss_ex_valid(iss_ex_valid), .iss_ex_func_unit(iss_ex_func_unit), .iss_ex_regdest(iss_ex_regdest),
    .iss_ex_writereg(iss_ex_writereg), .iss_ex_payload(iss_ex_payload), .iss_stall(iss_stall),
    .iss_pending_count(iss_pending_count), .iss_stall_cycles(iss_stall_cycles)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic instr(input logic [4:0] a, input logic [4:0] b, input logic ub,
                       input logic [4:0] d, input logic wr, input logic [1:0] fu, input logic [95:0] p);
    id_iss_valid = 1'b1; id_iss_srca = a; id_iss_srcb = b; id_iss_usesb = ub;
    id_iss_regdest = d; id_iss_writereg = wr; id_iss_fu = fu; id_iss_payload = p;
  endtask

  initial begin
    #2;
    chk("rst_valid", iss_ex_valid, 0);
    chk("rst_pend", iss_pending_count, 0);
    chk("rst_stallcnt", iss_stall_cycles, 0);
    chk("rst_payload", iss_ex_payload, 0);
    tick();
    reset = 1'b0;
    // add r3 <- r1,r2 on FU0
    instr(5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 2'd0, P1);
    #1 chk("first_nostall", iss_stall, 0);
    tick();
    chk("first_valid", iss_ex_valid, 1);
    chk("first_fu", iss_ex_func_unit, 0);
    chk("first_dest", iss_ex_regdest, 3);
    chk("first_payload", iss_ex_payload, P1);
    chk("first_pend", iss_pending_count, 1);
    // RAW on r3
    instr(5'd3, 5'd1, 1'b1, 5'd4, 1'b1, 2'd1, P2);
    #1 chk("raw_stall", iss_stall, 1);
    tick();
    chk("raw_cnt1", iss_stall_cycles, 1);
    chk("raw_drain", iss_ex_valid, 0);
    tick();
    chk("raw_cnt2", iss_stall_cycles, 2);
    wb_valid = 1'b1; wb_addr = 5'd3;
    #1 chk("raw_bypass", iss_stall, 0);
    tick();
    chk("raw_issue_valid", iss_ex_valid, 1);
    chk("raw_issue_dest", iss_ex_regdest, 4);
    chk("raw_issue_fu", iss_ex_func_unit, 1);
    chk("raw_pend", iss_pending_count, 1);
    chk("raw_cnt_hold", iss_stall_cycles, 2);
    wb_valid = 1'b0;
    // WAW on r5, then writeback racing a new write to r5
    instr(5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 2'd2, P1);
    #1 chk("r5_nostall", iss_stall, 0);
    tick();
    chk("r5_pend", iss_pending_count, 2);
    #1 chk("waw_stall", iss_stall, 1);
    tick();
    chk("waw_cnt", iss_stall_cycles, 3);
    wb_valid = 1'b1; wb_addr = 5'd5;
    #1 chk("waw_bypass", iss_stall, 0);
    tick();
    chk("setwins_pend", iss_pending_count, 2);
    chk("setwins_dest", iss_ex_regdest, 5);
    id_iss_valid = 1'b0;
    tick();
    chk("wb_r5_pend", iss_pending_count, 1);
    wb_addr = 5'd4;
    tick();
    chk("wb_r4_pend", iss_pending_count, 0);
    wb_valid = 1'b0;
    // Structural: FU2 busy for 4 cycles
    instr(5'd0, 5'd0, 1'b0, 5'd6, 1'b0, 2'd2, P1);
    tick();
    chk("fu2_valid", iss_ex_valid, 1);
    chk("fu2_fu", iss_ex_func_unit, 2);
    fu_ready = 3'b011;
    instr(5'd0, 5'd0, 1'b0, 5'd7, 1'b0, 2'd0, P2);
    #1 chk("struct_stall", iss_stall, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_valid", iss_ex_valid, 1);
      chk("hold_fu", iss_ex_func_unit, 2);
      chk("hold_payload", iss_ex_payload, P1);
    end
    chk("struct_cnt", iss_stall_cycles, 7);
    fu_ready = 3'b111;
    #1 chk("struct_release", iss_stall, 0);
    tick();
    chk("accept_fu", iss_ex_func_unit, 0);
    chk("accept_payload", iss_ex_payload, P2);
    chk("accept_cnt", iss_stall_cycles, 7);
    // r0 destination and r0 writeback
    instr(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 2'd1, P1);
    #1 chk("r0_nostall", iss_stall, 0);
    tick();
    chk("r0_valid", iss_ex_valid, 1);
    chk("r0_dest", iss_ex_regdest, 0);
    chk("r0_pend", iss_pending_count, 0);
    instr(5'd0, 5'd0, 1'b0, 5'd8, 1'b1, 2'd1, P1);
    tick();
    chk("r8_pend", iss_pending_count, 1);
    id_iss_valid = 1'b0; wb_valid = 1'b1; wb_addr = 5'd0;
    tick();
    chk("wb0_pend", iss_pending_count, 1);
    wb_addr = 5'd9;
    tick();
    chk("wb_notpend", iss_pending_count, 1);
    wb_addr = 5'd8;
    tick();
    chk("wb_r8_pend", iss_pending_count, 0);
    wb_valid = 1'b0;
    // Out-of-range FU
    instr(5'd0, 5'd0, 1'b0, 5'd9, 1'b1, 2'd3, P1);
    #1 chk("badfu_stall", iss_stall, 1);
    tick();
    chk("badfu_valid", iss_ex_valid, 0);
    chk("badfu_pend", iss_pending_count, 0);
    chk("badfu_cnt", iss_stall_cycles, 8);
    // Flush empties a blocked slot
    instr(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd1, P2);
    tick();
    chk("pre_flush_valid", iss_ex_valid, 1);
    fu_ready = 3'b101; iss_flush = 1'b1;
    #1 chk("flush_stall", iss_stall, 1);
    tick();
    chk("flush_valid", iss_ex_valid, 0);
    chk("flush_cnt", iss_stall_cycles, 9);
    iss_flush = 1'b0; fu_ready = 3'b111;
    // Back-to-back issue, then async reset mid-stream
    instr(5'd0, 5'd0, 1'b0, 5'd10, 1'b1, 2'd0, P1);
    tick();
    instr(5'd0, 5'd0, 1'b0, 5'd11, 1'b1, 2'd0, P1);
    tick();
    instr(5'd0, 5'd0, 1'b0, 5'd12, 1'b1, 2'd0, P1);
    tick();
    chk("b2b_pend", iss_pending_count, 3);
    chk("b2b_dest", iss_ex_regdest, 12);
    id_iss_valid = 1'b0; fu_ready = 3'b000;
    #1 reset = 1'b1;
    #1;
    chk("async_valid", iss_ex_valid, 0);
    chk("async_pend", iss_pending_count, 0);
    chk("async_dest", iss_ex_regdest, 0);
    chk("async_cnt", iss_stall_cycles, 0);
    tick();
    reset = 1'b0; fu_ready = 3'b111;
    // Stall counter saturation
    instr(5'd0, 5'd0, 1'b0, 5'd1, 1'b1, 2'd3, P1);
    repeat (65534) tick();
    chk("sat_fffe", iss_stall_cycles, 16'hFFFE);
    tick();
    chk("sat_ffff", iss_stall_cycles, 16'hFFFF);
    repeat (3) tick();
    chk("sat_hold", iss_stall_cycles, 16'hFFFF);
    id_iss_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
